multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Control FSM that runs the existing RV64I datapath (pc, bank, alu, aluControl) as a multi-cycle machine over one shared instruction/data memory.
- Each instruction takes several clock cycles. Fetch and load/store share a single memory port, which uses a req/ready handshake with variable latency.
- The block generates all datapath strobes, stops on ECALL, flags illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- TIMEOUT, 16: maximum number of cycles to wait for mem_ready in a memory state. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- opcode  in  7  instruction[6:0] taken from the datapath instruction register.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (store), 0 = read.
- iord  out  1  memory address select: 0 = pc_out, 1 = ALU result.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- pc_src  out  1  PC source: 0 = pc+4, 1 = branch target.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source: 1 = memory data, 0 = ALU result.
- alu_src  out  1  ALU operand B: 1 = immediate, 0 = register.
- alu_op  out  2  {ALUOp1, ALUOp0} to aluControl.
- halted  out  1  in HALT state.
- error  out  1  in ERROR state (sticky).
- state  out  4  current state encoding.
- instr_count  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - state = IDLE, instr_count = 0, timeout counter = 0.
  - All control outputs are 0, including mem_req; mem_req drops immediately, even mid-transfer.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, HALT=10, ERROR=11. Values 12-15 are unused; if reached, go to ERROR.
- Output timing: outputs are decoded from the registered state. Exceptions: ir_write and pc_write in FETCH are qualified by mem_ready, and pc_write in BRANCH is qualified by alu_zero. Any output not listed for a state is 0.
- IDLE: go to FETCH when en=1; otherwise stay.
- FETCH:
  - mem_req=1, iord=0, mem_we=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise hold.
- DECODE: one cycle, then branch on opcode:
  - 0110011 or 0010011 -> EXEC
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - 1110011 -> HALT
  - anything else -> ERROR
- EXEC: alu_op=10; alu_src=1 if opcode==0010011, else 0. Next state: WB_ALU.
- WB_ALU:
  - reg_write=1, mem_to_reg=0.
  - alu_src and alu_op are held at their EXEC values so the ALU result stays stable.
  - Retires the instruction.
- ADDR: alu_src=1, alu_op=00. Next state: MEM_RD for a load, MEM_WR for a store.
- MEM_RD / MEM_WR:
  - mem_req=1, iord=1, alu_src=1, alu_op=00; mem_we=1 only in MEM_WR.
  - Hold until mem_ready=1. Then MEM_RD goes to WB_MEM, and MEM_WR retires.
- WB_MEM: reg_write=1, mem_to_reg=1. Retires the instruction.
- BRANCH:
  - alu_src=0, alu_op=01, pc_src=1, pc_write=alu_zero.
  - Retires the instruction.
- Retire:
  - instr_count increments by 1 and wraps modulo 2^CNT_W.
  - Next state is FETCH if en=1, or IDLE if en=0. Dropping en therefore never aborts an instruction in flight.
- HALT: halted=1; the state is terminal until reset. ECALL is not counted as retired.
- ERROR: error=1; the state is terminal until reset.
- Handshake rules:
  - Once mem_req rises, it stays high, with iord and mem_we stable, until the cycle in which mem_ready=1 is sampled.
  - mem_ready while mem_req=0 is ignored.
  - Back-to-back transfers are legal, e.g. MEM_WR retire followed directly by FETCH.
- Timeout:
  - The counter clears on entry to any memory state and counts each cycle with mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT (with TIMEOUT>0), go to ERROR and drop mem_req.
  - If mem_ready=1 arrives in the same cycle the count reaches the limit, the transfer completes and no error is raised.
- Latency with mem_ready tied to 1:
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.

Test Plan:
- Reset release with en=1, mem_ready=1, opcode=0110011 -> state sequence 1,2,3,7,1. reg_write high only in state 7. instr_count=1 after 4 cycles.
- Load 0000011, with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> mem_req held with iord stable (iord=0 in FETCH, 1 in MEM_RD). The 3 stall cycles are added to each wait. WB_MEM has mem_to_reg=1. Total 11 cycles.
- BEQ 1100011 with alu_zero=1, then again with alu_zero=0 -> pc_write=1 with pc_src=1 in the first case; pc_write=0 in the second. Both take 3 cycles and increment the count.
- Opcode 0000000 -> ERROR after DECODE, error=1, count unchanged. Opcode 1110011 -> halted=1 and the state stays 10 for 20+ cycles.
- TIMEOUT=16 with mem_ready held low in FETCH -> ERROR after 16 wait cycles and mem_req=0. Repeat with mem_ready=1 on cycle 16 -> no error.
- Assert reset low mid-MEM_WR -> mem_req and mem_we drop to 0 asynchronously, before the next clock edge. After release, the FSM restarts from IDLE with instr_count=0. Separately, drop en during EXEC -> the instruction completes through WB_ALU, then the FSM enters IDLE.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Control FSM that runs an RV64I datapath (pc, register bank, alu, aluControl)
// as a multi-cycle machine. Instruction fetch and load/store share one memory
// port that uses a req/ready handshake with variable latency.
//
// Parameters
//   TIMEOUT : maximum number of cycles to wait for mem_ready in a memory state
//             (0 disables the timeout)
//   CNT_W   : width of the retired-instruction counter
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   en           in   run enable (sampled in IDLE and at retire)
//   opcode       in   instruction[6:0] from the instruction register
//   alu_zero     in   ALU zero flag (branch decision)
//   mem_ready    in   memory completes the current request this cycle
//   mem_req      out  memory request
//   mem_we       out  1 = write (store), 0 = read
//   iord         out  memory address select: 0 = pc, 1 = ALU result
//   ir_write     out  load the instruction register
//   pc_write     out  load the PC
//   pc_src       out  PC source: 0 = pc+4, 1 = branch target
//   reg_write    out  register file write enable
//   mem_to_reg   out  writeback source: 1 = memory data, 0 = ALU result
//   alu_src      out  ALU operand B: 1 = immediate, 0 = register
//   alu_op       out  {ALUOp1, ALUOp0} to aluControl
//   halted       out  FSM is in HALT
//   error        out  FSM is in ERROR (sticky until reset)
//   state        out  current state encoding
//   instr_count  out  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             error,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10,
    S_ERROR  = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Wait counter only needs to hold 0..TIMEOUT-1: the last wait cycle is
  // detected by comparison, not by counting up to TIMEOUT itself.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  state_t           r_state;
  logic [TMO_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_count;

  logic   w_tmo_hit;
  logic   w_is_imm;
  state_t w_retire_state;

  // The current wait cycle is the TIMEOUT-th one; a simultaneous mem_ready
  // still wins because the ready check comes first in the FSM.
  assign w_tmo_hit      = (TIMEOUT > 0) && (r_tmo == TMO_LAST);
  assign w_is_imm       = (opcode == OP_I);
  assign w_retire_state = en ? S_FETCH : S_IDLE;

  // ---------------------------------------------------------------------------
  // State, wait counter and retire counter.
  // r_tmo defaults to zero on every cycle and only increments while a memory
  // state is held waiting, so it is automatically cleared on entry to any
  // memory state (including back-to-back MEM_WR -> FETCH).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
      r_count <= '0;
    end else begin
      r_tmo <= '0;
      case (r_state)
        S_IDLE: begin
          if (en) r_state <= S_FETCH;
        end

        S_FETCH: begin
          if (mem_ready)      r_state <= S_DECODE;
          else if (w_tmo_hit) r_state <= S_ERROR;
          else                r_tmo   <= r_tmo + 1'b1;
        end

        S_DECODE: begin
          case (opcode)
            OP_R, OP_I:        r_state <= S_EXEC;
            OP_LOAD, OP_STORE: r_state <= S_ADDR;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_SYSTEM:         r_state <= S_HALT;
            default:           r_state <= S_ERROR;
          endcase
        end

        S_EXEC: r_state <= S_WB_ALU;

        S_ADDR: r_state <= (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;

        S_MEM_RD: begin
          if (mem_ready)      r_state <= S_WB_MEM;
          else if (w_tmo_hit) r_state <= S_ERROR;
          else                r_tmo   <= r_tmo + 1'b1;
        end

        S_MEM_WR: begin
          if (mem_ready) begin
            r_state <= w_retire_state;
            r_count <= r_count + 1'b1;
          end else if (w_tmo_hit) begin
            r_state <= S_ERROR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_WB_ALU, S_WB_MEM, S_BRANCH: begin
          r_state <= w_retire_state;
          r_count <= r_count + 1'b1;
        end

        S_HALT, S_ERROR: begin
          r_state <= r_state;
        end

        default: r_state <= S_ERROR;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath strobes decoded from the registered state. Because reset forces
  // the state to IDLE asynchronously, every strobe (mem_req included) drops
  // the moment reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        alu_op  = 2'b10;
        alu_src = w_is_imm;
      end
      S_WB_ALU: begin
        // Keep ALU controls identical to EXEC so the result is stable.
        reg_write = 1'b1;
        alu_op    = 2'b10;
        alu_src   = w_is_imm;
      end
      S_ADDR: begin
        alu_src = 1'b1;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        alu_src = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        alu_src = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_op   = 2'b01;
        pc_src   = 1'b1;
        pc_write = alu_zero;
      end
      default: begin
      end
    endcase
  end

  assign halted      = (r_state == S_HALT);
  assign error       = (r_state == S_ERROR);
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Directed bench for multicycle_sequencer. Inputs are driven 2 ns after each
// rising edge and outputs are sampled 1 ns later, away from the clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [6:0]  opcode;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, alu_src;
  logic [1:0]  alu_op;
  logic        halted, error;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  multicycle_sequencer #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .opcode      (opcode),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .halted      (halted),
    .error       (error),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock; leaves time 2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle after an input change, then sample.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    en        = 1'b0;
    opcode    = OP_R;
    alu_zero  = 1'b0;
    mem_ready = 1'b1;

    // ---------------- reset state ----------------
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_count", instr_count, 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_reg_write", 32'(reg_write), 0);

    // ---------------- R-type, mem_ready tied high ----------------
    #10;
    reset = 1'b1;
    en    = 1'b1;
    tick(); settle();
    check("r_fetch_state", 32'(state), 1);
    check("r_fetch_mem_req", 32'(mem_req), 1);
    check("r_fetch_iord", 32'(iord), 0);
    check("r_fetch_ir_write", 32'(ir_write), 1);
    check("r_fetch_pc_write", 32'(pc_write), 1);
    check("r_fetch_reg_write", 32'(reg_write), 0);
    tick(); settle();
    check("r_decode_state", 32'(state), 2);
    check("r_decode_reg_write", 32'(reg_write), 0);
    tick(); settle();
    check("r_exec_state", 32'(state), 3);
    check("r_exec_alu_op", 32'(alu_op), 2);
    check("r_exec_alu_src", 32'(alu_src), 0);
    check("r_exec_reg_write", 32'(reg_write), 0);
    tick(); settle();
    check("r_wb_state", 32'(state), 7);
    check("r_wb_reg_write", 32'(reg_write), 1);
    check("r_wb_mem_to_reg", 32'(mem_to_reg), 0);
    check("r_wb_alu_op", 32'(alu_op), 2);
    check("r_wb_count", instr_count, 0);
    tick(); settle();
    check("r_next_fetch_state", 32'(state), 1);
    check("r_count", instr_count, 1);

    // ---------------- load with 3 stall cycles in FETCH and MEM_RD ----------------
    mem_ready = 1'b0;
    opcode    = OP_LOAD;
    settle();
    check("ld_f_stall1_state", 32'(state), 1);
    check("ld_f_stall1_req", 32'(mem_req), 1);
    check("ld_f_stall1_iord", 32'(iord), 0);
    check("ld_f_stall1_ir_write", 32'(ir_write), 0);
    check("ld_f_stall1_pc_write", 32'(pc_write), 0);
    tick(); settle();
    check("ld_f_stall2_state", 32'(state), 1);
    check("ld_f_stall2_req", 32'(mem_req), 1);
    tick(); settle();
    check("ld_f_stall3_state", 32'(state), 1);
    check("ld_f_stall3_iord", 32'(iord), 0);
    tick();
    mem_ready = 1'b1;
    settle();
    check("ld_f_ready_state", 32'(state), 1);
    check("ld_f_ready_ir_write", 32'(ir_write), 1);
    tick();
    mem_ready = 1'b0;
    settle();
    check("ld_decode_state", 32'(state), 2);
    tick(); settle();
    check("ld_addr_state", 32'(state), 4);
    check("ld_addr_alu_src", 32'(alu_src), 1);
    check("ld_addr_alu_op", 32'(alu_op), 0);
    check("ld_addr_mem_req", 32'(mem_req), 0);
    tick(); settle();
    check("ld_rd_stall1_state", 32'(state), 5);
    check("ld_rd_stall1_req", 32'(mem_req), 1);
    check("ld_rd_stall1_iord", 32'(iord), 1);
    check("ld_rd_stall1_we", 32'(mem_we), 0);
    tick(); settle();
    check("ld_rd_stall2_state", 32'(state), 5);
    check("ld_rd_stall2_iord", 32'(iord), 1);
    tick(); settle();
    check("ld_rd_stall3_state", 32'(state), 5);
    check("ld_rd_stall3_req", 32'(mem_req), 1);
    tick();
    mem_ready = 1'b1;
    settle();
    check("ld_rd_ready_state", 32'(state), 5);
    tick(); settle();
    check("ld_wbmem_state", 32'(state), 8);
    check("ld_wbmem_mem_to_reg", 32'(mem_to_reg), 1);
    check("ld_wbmem_reg_write", 32'(reg_write), 1);
    check("ld_wbmem_count", instr_count, 1);
    tick(); settle();
    check("ld_done_state", 32'(state), 1);
    check("ld_count", instr_count, 2);

    // ---------------- BEQ taken, then not taken ----------------
    opcode   = OP_BRANCH;
    alu_zero = 1'b1;
    tick(); settle();
    check("beq1_decode_state", 32'(state), 2);
    tick(); settle();
    check("beq1_branch_state", 32'(state), 9);
    check("beq1_pc_write", 32'(pc_write), 1);
    check("beq1_pc_src", 32'(pc_src), 1);
    check("beq1_alu_op", 32'(alu_op), 1);
    check("beq1_alu_src", 32'(alu_src), 0);
    tick(); settle();
    check("beq1_done_state", 32'(state), 1);
    check("beq1_count", instr_count, 3);
    alu_zero = 1'b0;
    tick(); settle();
    check("beq0_decode_state", 32'(state), 2);
    tick(); settle();
    check("beq0_branch_state", 32'(state), 9);
    check("beq0_pc_write", 32'(pc_write), 0);
    check("beq0_pc_src", 32'(pc_src), 1);
    tick(); settle();
    check("beq0_done_state", 32'(state), 1);
    check("beq0_count", instr_count, 4);

    // ---------------- illegal opcode ----------------
    opcode = 7'b0000000;
    tick(); settle();
    check("ill_decode_state", 32'(state), 2);
    tick(); settle();
    check("ill_error_state", 32'(state), 11);
    check("ill_error_flag", 32'(error), 1);
    check("ill_mem_req", 32'(mem_req), 0);
    tick(); settle();
    check("ill_error_sticky", 32'(state), 11);
    check("ill_count", instr_count, 4);

    // ---------------- ECALL halts, not counted ----------------
    reset = 1'b0;
    settle();
    check("rst2_state", 32'(state), 0);
    check("rst2_count", instr_count, 0);
    check("rst2_error", 32'(error), 0);
    reset  = 1'b1;
    opcode = OP_ECALL;
    tick(); settle();
    check("ecall_fetch_state", 32'(state), 1);
    tick(); settle();
    check("ecall_decode_state", 32'(state), 2);
    tick(); settle();
    check("ecall_halt_state", 32'(state), 10);
    check("ecall_halted", 32'(halted), 1);
    for (int i = 0; i < 20; i++) tick();
    settle();
    check("ecall_halt_hold_state", 32'(state), 10);
    check("ecall_halt_hold_halted", 32'(halted), 1);
    check("ecall_count", instr_count, 0);

    // ---------------- FETCH timeout ----------------
    reset     = 1'b0;
    mem_ready = 1'b0;
    opcode    = OP_R;
    settle();
    reset = 1'b1;
    tick(); settle();
    check("tmo_fetch_state", 32'(state), 1);
    for (int i = 0; i < 15; i++) tick();
    settle();
    check("tmo_wait16_state", 32'(state), 1);
    check("tmo_wait16_req", 32'(mem_req), 1);
    tick(); settle();
    check("tmo_error_state", 32'(state), 11);
    check("tmo_error_flag", 32'(error), 1);
    check("tmo_error_req", 32'(mem_req), 0);

    // ---------------- ready on the 16th wait cycle: no error ----------------
    reset = 1'b0;
    settle();
    reset = 1'b1;
    tick(); settle();
    check("tmo2_fetch_state", 32'(state), 1);
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    opcode    = OP_STORE;
    settle();
    check("tmo2_wait16_state", 32'(state), 1);
    tick(); settle();
    check("tmo2_decode_state", 32'(state), 2);
    check("tmo2_no_error", 32'(error), 0);

    // ---------------- store, back-to-back fetch, reset mid-MEM_WR ----------------
    tick(); settle();
    check("st1_addr_state", 32'(state), 4);
    tick(); settle();
    check("st1_memwr_state", 32'(state), 6);
    check("st1_memwr_we", 32'(mem_we), 1);
    check("st1_memwr_iord", 32'(iord), 1);
    tick(); settle();
    check("st1_b2b_fetch_state", 32'(state), 1);
    check("st1_b2b_fetch_req", 32'(mem_req), 1);
    check("st1_b2b_fetch_we", 32'(mem_we), 0);
    check("st1_count", instr_count, 1);
    tick();
    mem_ready = 1'b0;
    settle();
    check("st2_decode_state", 32'(state), 2);
    tick(); settle();
    check("st2_addr_state", 32'(state), 4);
    tick(); settle();
    check("st2_memwr_state", 32'(state), 6);
    check("st2_memwr_req", 32'(mem_req), 1);
    check("st2_memwr_we", 32'(mem_we), 1);
    // Asynchronous reset in the middle of the write, well before the next edge.
    reset = 1'b0;
    settle();
    check("async_rst_req", 32'(mem_req), 0);
    check("async_rst_we", 32'(mem_we), 0);
    check("async_rst_state", 32'(state), 0);
    check("async_rst_count", instr_count, 0);

    // ---------------- drop en during EXEC ----------------
    reset     = 1'b1;
    en        = 1'b1;
    mem_ready = 1'b1;
    opcode    = OP_R;
    tick(); settle();
    check("en_fetch_state", 32'(state), 1);
    tick(); settle();
    check("en_decode_state", 32'(state), 2);
    tick();
    en = 1'b0;
    settle();
    check("en_exec_state", 32'(state), 3);
    tick(); settle();
    check("en_wb_state", 32'(state), 7);
    check("en_wb_reg_write", 32'(reg_write), 1);
    tick(); settle();
    check("en_idle_state", 32'(state), 0);
    check("en_idle_count", instr_count, 1);
    tick(); settle();
    check("en_idle_hold_state", 32'(state), 0);
    check("en_idle_hold_req", 32'(mem_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
